// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle logic/arith ops plus iterative MUL/DIVU behind start/busy/done.
// Define SEQ_ALU_DIV_EN to build the restoring divider; otherwise op 111 behaves as NOTHING.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] lop,
    input  logic [WIDTH-1:0] rop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [2:0] OP_DIVU = 3'b111;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
`ifdef SEQ_ALU_DIV_EN
        , S_DIV = 2'd3
`endif
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    // Shared iteration registers: a = multiplier / dividend-quotient, b = multiplicand / divisor, r = product high / remainder.
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_a_nxt, mul_r_nxt;

    // NOTE: always_comb assigns a default first so every path drives single_res and no latch is inferred.
    always_comb begin
        single_res = '0;
        case (op)
            OP_ADD:  single_res = lop + rop;
            OP_SUB:  single_res = lop - rop;
            OP_AND:  single_res = lop & rop;
            OP_OR:   single_res = lop | rop;
            OP_SLT:  single_res = ($signed(lop) < $signed(rop)) ? WIDTH'(1) : '0;
            OP_NOP:  single_res = '0;
            default: single_res = '0;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand, then shift {r, a} right by one.
    always_comb begin
        mul_sum   = {1'b0, r_q} + (a_q[0] ? {1'b0, b_q} : '0);
        mul_r_nxt = mul_sum[WIDTH:1];
        mul_a_nxt = {mul_sum[0], a_q[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, div_r_nxt, div_a_nxt;

    // One restoring step; with a zero divisor every trial succeeds, yielding all-ones quotient and remainder = lop.
    always_comb begin
        div_shift = {r_q, a_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        div_r_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_a_nxt = {a_q[WIDTH-2:0], div_ge};
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b1;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    if (start) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                            busy  <= 1'b1;
                            cnt   <= CW'(WIDTH);
                            a_q   <= rop;
                            b_q   <= lop;
                            r_q   <= '0;
`ifdef SEQ_ALU_DIV_EN
                        end else if (op == OP_DIVU) begin
                            state <= S_DIV;
                            busy  <= 1'b1;
                            cnt   <= CW'(WIDTH);
                            a_q   <= lop;
                            b_q   <= rop;
                            r_q   <= '0;
`endif
                        end else begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= single_res;
                            hi     <= '0;
                            zero   <= (single_res == '0);
                        end
                    end
                end
                S_MUL: begin
                    a_q <= mul_a_nxt;
                    r_q <= mul_r_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= mul_a_nxt;
                        hi     <= mul_r_nxt;
                        zero   <= (mul_a_nxt == '0);
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    a_q <= div_a_nxt;
                    r_q <= div_r_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= div_a_nxt;
                        hi     <= div_r_nxt;
                        zero   <= (div_a_nxt == '0);
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); follows SEQ_ALU_DIV_EN for the op 111 expectations.
module tb_seq_alu;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] lop = '0;
    logic [WIDTH-1:0] rop = '0;
    logic             busy, done, zero;
    logic [WIDTH-1:0] result, hi;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .lop    (lop),
        .rop    (rop),
        .busy   (busy),
        .done   (done),
        .result (result),
        .hi     (hi),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns at the negedge of the cycle after acceptance.
    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        lop   = l;
        rop   = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic single(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] l,
                          input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] exp_res);
        issue(o, l, r);
        check({tag, ".done"},   64'(done),   64'd1);
        check({tag, ".result"}, 64'(result), 64'(exp_res));
        check({tag, ".hi"},     64'(hi),     64'd0);
        check({tag, ".zero"},   64'(zero),   64'(exp_res == '0));
    endtask

    task automatic iter(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] l,
                        input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] exp_res,
                        input logic [WIDTH-1:0] exp_hi, input bit inject);
        int n;
        issue(o, l, r);
        n = 0;
        while (busy && n < 100) begin
            if (inject && n == 10) begin
                start = 1'b1;
                op    = OP_ADD;
                lop   = 32'd3;
                rop   = 32'd4;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".busy_cycles"}, 64'(n),      64'(WIDTH));
        check({tag, ".done"},        64'(done),   64'd1);
        check({tag, ".result"},      64'(result), 64'(exp_res));
        check({tag, ".hi"},          64'(hi),     64'(exp_hi));
        check({tag, ".zero"},        64'(zero),   64'(exp_res == '0));
        @(negedge clk);
        check({tag, ".done_drop"},   64'(done),   64'd0);
        check({tag, ".held"},        64'(result), 64'(exp_res));
    endtask

    initial begin
        bit seen_done;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.busy",   64'(busy),   64'd0);
        check("reset.done",   64'(done),   64'd0);
        check("reset.result", 64'(result), 64'd0);
        check("reset.hi",     64'(hi),     64'd0);
        check("reset.zero",   64'(zero),   64'd1);

        single("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single("slt_neg",  OP_SLT, 32'hFFFF_FFFE, 32'd1, 32'd1);
        single("slt_swap", OP_SLT, 32'd1, 32'hFFFF_FFFE, 32'd0);
        single("sub_neg",  OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        single("nop",      OP_NOP, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);

        iter("mul_ovf", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b1);
        iter("mul_small", OP_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);

`ifdef SEQ_ALU_DIV_EN
        iter("divu", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        iter("divu_zero", OP_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0);
`else
        single("divu_off", OP_DIV, 32'd100, 32'd7, 32'd0);
`endif

        // Abort a MUL after 10 busy cycles.
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);
        repeat (9) @(negedge clk);
        check("abort.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy",   64'(busy),   64'd0);
        check("abort.done",   64'(done),   64'd0);
        check("abort.result", 64'(result), 64'd0);
        check("abort.hi",     64'(hi),     64'd0);
        check("abort.zero",   64'(zero),   64'd1);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort.no_done", 64'(seen_done), 64'd0);
        single("add_after_abort", OP_ADD, 32'd3, 32'd4, 32'd7);

        // Request coinciding with reset is dropped.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        op    = OP_ADD;
        lop   = 32'd1;
        rop   = 32'd1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start.done",   64'(done),   64'd0);
        check("rst_start.result", 64'(result), 64'd0);
        @(negedge clk);
        check("rst_start.dropped", 64'(done), 64'd0);

        // Back-to-back: second request issued in the DONE cycle.
        @(negedge clk);
        start = 1'b1;
        op    = OP_AND;
        lop   = 32'h0000_F0F0;
        rop   = 32'h0000_FF00;
        @(negedge clk);
        check("b2b.and_done",   64'(done),   64'd1);
        check("b2b.and_result", 64'(result), 64'h0000_F000);
        op  = OP_OR;
        lop = 32'd1;
        rop = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check("b2b.or_done",   64'(done),   64'd1);
        check("b2b.or_result", 64'(result), 64'd3);
        @(negedge clk);
        check("b2b.idle_done", 64'(done),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the datapath ALU for the pipelined core's execute stage. It executes single-cycle logic/arithmetic ops and iterative unsigned multiply and divide behind a start/busy/done handshake. Results are held in output registers until the next operation completes. The hazard unit stalls the pipeline on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request; sampled only while `busy`=0.
- `op` input 3: operation code, sampled with `start`.
- `lop` input WIDTH: left operand, sampled with `start`.
- `rop` input WIDTH: right operand, sampled with `start`.
- `busy` output 1: iterative op in progress; new requests ignored.
- `done` output 1: one-cycle pulse when `result`/`hi`/`zero` are updated.
- `result` output WIDTH: low result (sum, difference, product low, quotient).
- `hi` output WIDTH: product high half (MUL) or remainder (DIVU); 0 for other ops.
- `zero` output 1: registered, equals (`result`==0), updated with `result`.

## Operation
- Op codes:
  - 000 NOTHING: `result`=0.
  - 001 ADD: `lop`+`rop`, carry dropped.
  - 010 SUB: `lop`−`rop`, modulo 2^WIDTH.
  - 011 AND.
  - 100 OR.
  - 101 SLT: signed two's-complement compare; `result`=1 if `lop`<`rop`, else 0.
  - 110 MUL: unsigned shift-add; {`hi`,`result`}=`lop`×`rop` (2·WIDTH bits).
  - 111 DIVU: unsigned restoring division; `result`=quotient, `hi`=remainder.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE/DONE + `start` + single-cycle op → DONE, outputs written.
  - IDLE/DONE + `start` + op 110 → MUL, iteration counter loaded with WIDTH.
  - IDLE/DONE + `start` + op 111 → DIV, iteration counter loaded with WIDTH.
  - MUL/DIV: one bit per cycle; counter decrements; at counter=1 → DONE, outputs written.
  - DONE without `start` → IDLE.
- Counter width: $clog2(WIDTH)+1.
- `busy`=1 exactly in MUL and DIV. `done`=1 exactly in DONE.
- `start` while `busy`: ignored, no effect on operands or state.
- Operands are latched internally at accept; changing `lop`/`rop`/`op` during MUL/DIV has no effect.
- Divide by zero: `result`=all ones, `hi`=`lop`, no error flag.
- Outputs hold their last values in IDLE and while busy; they change only on entry to DONE.

## Timing
- Reset: state IDLE; `busy`=0, `done`=0, `result`=0, `hi`=0, `zero`=1.
- Reset takes priority over everything; reset during MUL/DIV aborts the op with no `done` pulse.
- Single-cycle ops: `start` sampled at edge N → `done`=1 and outputs valid during cycle N+1 (latency 1).
- MUL/DIV: `start` sampled at edge N → `busy`=1 for cycles N+1..N+WIDTH; `done`=1 in cycle N+WIDTH+1 (latency WIDTH+1).
- Back-to-back: `start` in the DONE cycle is accepted; `done` may stay high in consecutive cycles for consecutive single-cycle ops.
- `start` and `rst` in the same cycle: reset wins; the request is dropped.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIVU and the DIV state are implemented as above.
- `SEQ_ALU_DIV_EN` undefined: divider logic is omitted; op 111 behaves exactly as NOTHING (latency 1, `result`=0, `hi`=0, `zero`=1); DIV state is unreachable and not synthesised.

## Test plan
- Reset then ADD, WIDTH=32: lop=0xFFFFFFFF, rop=1 → next cycle `done`=1, `result`=0, `zero`=1, `hi`=0.
- SLT signed: lop=0xFFFFFFFE (−2), rop=1 → `result`=1; swap operands → `result`=0; SUB 5−7 → 0xFFFFFFFE.
- MUL: lop=0xFFFFFFFF, rop=2 → `busy` high 32 cycles, `done` at cycle 33, `hi`=1, `result`=0xFFFFFFFE; a `start` with op ADD issued mid-op is ignored.
- DIVU (macro on): 100/7 → `result`=14, `hi`=2, latency 33; 9/0 → `result`=0xFFFFFFFF, `hi`=9. Macro off: op 111 → `done` next cycle, `result`=0.
- Reset at cycle 10 of a MUL → no `done` pulse, all outputs at reset values, next ADD 3+4 → 7 with latency 1.
- Back-to-back: AND 0xF0F0&0xFF00 in IDLE, then OR 0x1|0x2 issued in the DONE cycle → `done` high two consecutive cycles, results 0xF000 then 0x3.
